// File: rtl/temp_sample_scheduler.sv
// Periodic I2C temperature read sequencer: requests a sample every SAMPLE_CYC clocks,
// averages 2**AVG_LOG2 good samples, publishes Celsius, alternates display unit, tracks failures.
module temp_sample_scheduler #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int SAMPLE_MS   = 250,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 50_000,
    parameter int UNIT_HOLD   = 4,
    parameter int STALE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    output logic       rd_req,
    input  logic       rd_ack,
    input  logic       rd_err,
    input  logic [7:0] rd_data,
    output logic [7:0] temp_c,
    output logic       temp_valid,
    output logic       upd_pulse,
    output logic       unit_f,
    output logic       stale,
    output logic [7:0] err_cnt,
    output logic [2:0] dbg_state
);

    localparam int SAMPLE_CYC = CLK_HZ / 1000 * SAMPLE_MS;
    localparam int NSAMP      = 2 ** AVG_LOG2;
    localparam int TICK_W     = $clog2(SAMPLE_CYC + 1);
    localparam int TO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam int ACC_W      = 8 + AVG_LOG2;
    localparam int CNT_W      = AVG_LOG2 + 1;
    localparam int RUN_W      = $clog2(STALE_LIMIT + 1);
    localparam int PUB_W      = $clog2(UNIT_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        ACC     = 3'd3,
        PUBLISH = 3'd4
    } state_t;

    state_t             state_q;
    logic [TICK_W-1:0]  tick_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   smp_cnt_q;
    logic [RUN_W-1:0]   fail_run_q;
    logic [PUB_W-1:0]   pub_cnt_q;
    logic [7:0]         data_q;
    logic [7:0]         temp_c_q;
    logic [7:0]         err_cnt_q;
    logic               pending_q;
    logic               rd_req_q;
    logic               temp_valid_q;
    logic               upd_pulse_q;
    logic               unit_f_q;
    logic               stale_q;
    logic               tick;
    logic               fail;

    assign tick = (tick_cnt_q == TICK_W'(SAMPLE_CYC - 1));

    // A simultaneous ack and err is a failed transfer; the error wins.
    assign fail = rd_err || (!rd_ack && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            to_cnt_q     <= '0;
            acc_q        <= '0;
            smp_cnt_q    <= '0;
            fail_run_q   <= '0;
            pub_cnt_q    <= '0;
            data_q       <= '0;
            temp_c_q     <= '0;
            err_cnt_q    <= '0;
            pending_q    <= 1'b0;
            rd_req_q     <= 1'b0;
            temp_valid_q <= 1'b0;
            upd_pulse_q  <= 1'b0;
            unit_f_q     <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            upd_pulse_q <= 1'b0;
            // Overrun: remember one tick that arrives while a read is in flight.
            if (tick && state_q != IDLE) pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (tick || pending_q) begin
                        pending_q <= 1'b0;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    rd_req_q <= 1'b1;
                    to_cnt_q <= '0;
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (fail) begin
                        rd_req_q <= 1'b0;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                        if (fail_run_q != RUN_W'(STALE_LIMIT)) fail_run_q <= fail_run_q + 1'b1;
                        if (fail_run_q >= RUN_W'(STALE_LIMIT - 1)) stale_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (rd_ack) begin
                        rd_req_q <= 1'b0;
                        data_q   <= rd_data;
                        state_q  <= ACC;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ACC: begin
                    acc_q      <= acc_q + ACC_W'(data_q);
                    smp_cnt_q  <= smp_cnt_q + 1'b1;
                    fail_run_q <= '0;
                    state_q    <= (smp_cnt_q == CNT_W'(NSAMP - 1)) ? PUBLISH : IDLE;
                end
                PUBLISH: begin
                    temp_c_q     <= 8'(acc_q >> AVG_LOG2);
                    upd_pulse_q  <= 1'b1;
                    temp_valid_q <= 1'b1;
                    stale_q      <= 1'b0;
                    acc_q        <= '0;
                    smp_cnt_q    <= '0;
                    if (pub_cnt_q == PUB_W'(UNIT_HOLD - 1)) begin
                        pub_cnt_q <= '0;
                        unit_f_q  <= ~unit_f_q;
                    end else begin
                        pub_cnt_q <= pub_cnt_q + 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_req     = rd_req_q;
    assign temp_c     = temp_c_q;
    assign temp_valid = temp_valid_q;
    assign upd_pulse  = upd_pulse_q;
    assign unit_f     = unit_f_q;
    assign stale      = stale_q;
    assign err_cnt    = err_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_temp_sample_scheduler.sv
// Randomized bench for temp_sample_scheduler against a sample-list reference model.
module tb_temp_sample_scheduler;

    localparam int CLK_HZ      = 1000;
    localparam int SAMPLE_MS   = 40;
    localparam int SAMPLE_CYC  = CLK_HZ / 1000 * SAMPLE_MS;
    localparam int AVG_LOG2    = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int UNIT_HOLD   = 4;
    localparam int STALE_LIMIT = 3;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_TO   = 2;
    localparam int K_BOTH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_req;
    logic       rd_ack = 1'b0;
    logic       rd_err = 1'b0;
    logic [7:0] rd_data = 8'd0;
    logic [7:0] temp_c;
    logic       temp_valid;
    logic       upd_pulse;
    logic       unit_f;
    logic       stale;
    logic [7:0] err_cnt;
    logic [2:0] dbg_state;

    int n_chk  = 0;
    int n_fail = 0;
    int upd_seen = 0;

    // reference model state
    int samp_q[$];
    int m_err, m_run, m_temp, m_pub, m_pub_total;
    bit m_stale, m_valid, m_unit;

    temp_sample_scheduler #(
        .CLK_HZ(CLK_HZ), .SAMPLE_MS(SAMPLE_MS), .AVG_LOG2(AVG_LOG2),
        .TIMEOUT_CYC(TIMEOUT_CYC), .UNIT_HOLD(UNIT_HOLD), .STALE_LIMIT(STALE_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_ack(rd_ack), .rd_err(rd_err),
        .rd_data(rd_data), .temp_c(temp_c), .temp_valid(temp_valid),
        .upd_pulse(upd_pulse), .unit_f(unit_f), .stale(stale), .err_cnt(err_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (upd_pulse) upd_seen++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        samp_q.delete();
        m_err = 0; m_run = 0; m_temp = 0; m_pub = 0;
        m_stale = 0; m_valid = 0; m_unit = 0;
    endtask

    task automatic model_fail();
        if (m_err < 255) m_err++;
        if (m_run < STALE_LIMIT) m_run++;
        if (m_run >= STALE_LIMIT) m_stale = 1;
    endtask

    task automatic model_good(input int d);
        int sum;
        samp_q.push_back(d);
        m_run = 0;
        if (samp_q.size() == (1 << AVG_LOG2)) begin
            sum = 0;
            foreach (samp_q[i]) sum += samp_q[i];
            m_temp = sum / (1 << AVG_LOG2);
            m_valid = 1;
            m_stale = 0;
            samp_q.delete();
            m_pub++;
            m_pub_total++;
            if (m_pub % UNIT_HOLD == 0) m_unit = ~m_unit;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".err_cnt"}, err_cnt, m_err);
        check({tag, ".stale"}, stale, m_stale);
        check({tag, ".temp_c"}, temp_c, m_temp);
        check({tag, ".temp_valid"}, temp_valid, m_valid);
        check({tag, ".unit_f"}, unit_f, m_unit);
        check({tag, ".upd_count"}, upd_seen, m_pub_total);
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        ok = 1;
        while (!rd_req && n < 4 * SAMPLE_CYC) begin
            @(negedge clk);
            n++;
        end
        if (!rd_req) begin
            check("req_wait_timeout", 0, 1);
            ok = 0;
        end
    endtask

    // One read transaction: kind selects the responder behaviour.
    task automatic do_txn(input int kind, input int data, input int dly, input string tag);
        bit ok;
        int n;
        wait_req(ok);
        if (!ok) return;
        if (kind == K_TO) begin
            n = 0;
            while (rd_req && n < 4 * TIMEOUT_CYC) begin
                @(negedge clk);
                n++;
            end
            check({tag, ".req_len"}, n, TIMEOUT_CYC);
            model_fail();
        end else begin
            repeat (dly) @(negedge clk);
            rd_data = 8'(data);
            rd_ack = (kind == K_ACK || kind == K_BOTH);
            rd_err = (kind == K_ERR || kind == K_BOTH);
            @(negedge clk);
            rd_ack = 1'b0;
            rd_err = 1'b0;
            rd_data = 8'(($urandom & 8'hFF));
            check({tag, ".req_drop"}, rd_req, 0);
            if (kind == K_ACK) model_good(data);
            else model_fail();
        end
        repeat (4) @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic check_first_req(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            rd_ack = 1'b0;
            n++;
        end while (!rd_req && n < 4 * SAMPLE_CYC);
        check({tag, ".first_req_cyc"}, n, SAMPLE_CYC + 1);
    endtask

    initial begin
        int k, r;
        model_reset();
        m_pub_total = 0;

        // T1 reset / idle
        repeat (3) @(negedge clk);
        check("t1.rd_req", rd_req, 0);
        check_outputs("t1");
        rst = 1'b1;
        check_first_req("t1");

        // T2 averaging
        do_txn(K_ACK, 20, 1, "t2a");
        do_txn(K_ACK, 21, 0, "t2b");
        do_txn(K_ACK, 22, 3, "t2c");
        do_txn(K_ACK, 24, 2, "t2d");
        check("t2.temp_c", temp_c, 21);

        // T3 failures then recovery
        for (int i = 0; i < 3; i++) do_txn(K_ERR, 0, 1, "t3err");
        check("t3.stale", stale, 1);
        for (int i = 0; i < 4; i++) do_txn(K_ACK, 30, 2, "t3ack");
        check("t3.temp_c", temp_c, 30);
        check("t3.err_cnt", err_cnt, 3);

        // T4 timeout and collision with a partial accumulation in flight
        do_txn(K_ACK, 100, 0, "t4a");
        do_txn(K_TO, 0, 0, "t4to");
        do_txn(K_BOTH, 255, 1, "t4both");
        do_txn(K_ACK, 104, 0, "t4b");
        do_txn(K_ACK, 108, 0, "t4c");
        do_txn(K_ACK, 112, 0, "t4d");

        // randomized traffic
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            k = (r < 65) ? K_ACK : (r < 80) ? K_ERR : (r < 90) ? K_TO : K_BOTH;
            do_txn(k, $urandom_range(0, 255), $urandom_range(0, TIMEOUT_CYC - 3), "rnd");
        end

        // T5 error saturation
        for (int i = 0; i < 300; i++) do_txn(K_ERR, 0, 0, "t5err");
        check("t5.err_sat", err_cnt, 255);

        // T6 reset mid-transfer, then a late ack after release
        begin
            bit ok;
            wait_req(ok);
            #2 rst = 1'b0;
            #1 check("t6.req_async_drop", rd_req, 0);
            model_reset();
            @(negedge clk);
            check_outputs("t6rst");
            rst = 1'b1;
            rd_data = 8'd77;
            rd_ack = 1'b1;
            check_first_req("t6");
            check("t6.err_cnt", err_cnt, 0);
            check("t6.temp_valid", temp_valid, 0);
            do_txn(K_ACK, 50, 0, "t6a");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
